// File: rtl/xor_multiport_ram_pipelined.sv
// Multiport RAM built from XOR-coded async-read banks, one bank per port.
// Writes go S1 (capture + encode read) -> S2 (bank write); forwarding hides the pipeline.
module xor_multiport_ram_pipelined #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1024,
  parameter int PORTS = 32,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AW-1:0]    addr [PORTS],
  input  logic [PORTS-1:0] en,
  input  logic [WIDTH-1:0] d    [PORTS],
  output logic [WIDTH-1:0] q    [PORTS]
);

  logic [PORTS-1:0] s1_valid_d, s1_valid_q;
  logic [AW-1:0]    s1_addr_d  [PORTS];
  logic [AW-1:0]    s1_addr_q  [PORTS];
  logic [WIDTH-1:0] s1_data_d  [PORTS];
  logic [WIDTH-1:0] s1_data_q  [PORTS];

  logic [PORTS-1:0] s2_valid_d, s2_valid_q;
  logic [AW-1:0]    s2_addr_d  [PORTS];
  logic [AW-1:0]    s2_addr_q  [PORTS];
  logic [WIDTH-1:0] s2_word_d  [PORTS];
  logic [WIDTH-1:0] s2_word_q  [PORTS];

  logic [WIDTH-1:0] q_d [PORTS];
  logic [WIDTH-1:0] q_q [PORTS];

  // rd_enc[bank][port]: bank at the S1 address of port; rd_dat[bank][port]: bank at live addr
  logic [WIDTH-1:0] rd_enc [PORTS][PORTS];
  logic [WIDTH-1:0] rd_dat [PORTS][PORTS];

  genvar gi, gj;
  generate
    for (gi = 0; gi < PORTS; gi++) begin : g_bank
      logic [WIDTH-1:0] mem [DEPTH];

      always_ff @(posedge clk) begin
        if (s2_valid_q[gi]) begin
          mem[s2_addr_q[gi]] <= s2_word_q[gi];
        end
      end

      for (gj = 0; gj < PORTS; gj++) begin : g_rd
        assign rd_enc[gi][gj] = mem[s1_addr_q[gj]];
        assign rd_dat[gi][gj] = mem[addr[gj]];
      end

      assign q[gi] = q_q[gi];
    end
  endgenerate

  // Encode: stored word = data ^ other banks, with the S2 write still pending forwarded in.
  always_comb begin
    s1_valid_d = en;
    s2_valid_d = s1_valid_q;
    for (int p = 0; p < PORTS; p++) begin
      s1_addr_d[p] = addr[p];
      s1_data_d[p] = d[p];
      s2_addr_d[p] = s1_addr_q[p];
      s2_word_d[p] = s1_data_q[p];
      for (int j = 0; j < PORTS; j++) begin
        if (j != p) begin
          s2_word_d[p] = s2_word_d[p] ^
            ((s2_valid_q[j] && (s2_addr_q[j] == s1_addr_q[p])) ? s2_word_q[j] : rd_enc[j][p]);
        end
      end
    end
  end

  // Read: each bank contributes its newest value, S1 before S2 before the array itself.
  always_comb begin
    for (int p = 0; p < PORTS; p++) begin
      q_d[p] = '0;
      for (int b = 0; b < PORTS; b++) begin
        if (s1_valid_q[b] && (s1_addr_q[b] == addr[p])) begin
          q_d[p] = q_d[p] ^ s2_word_d[b];
        end else if (s2_valid_q[b] && (s2_addr_q[b] == addr[p])) begin
          q_d[p] = q_d[p] ^ s2_word_q[b];
        end else begin
          q_d[p] = q_d[p] ^ rd_dat[b][p];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= '0;
      s2_valid_q <= '0;
      for (int p = 0; p < PORTS; p++) begin
        q_q[p] <= '0;
      end
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      for (int p = 0; p < PORTS; p++) begin
        q_q[p] <= q_d[p];
      end
    end
  end

  // Payload registers need no reset; the valid flags gate everything they feed.
  always_ff @(posedge clk) begin
    for (int p = 0; p < PORTS; p++) begin
      s1_addr_q[p] <= s1_addr_d[p];
      s1_data_q[p] <= s1_data_d[p];
      s2_addr_q[p] <= s2_addr_d[p];
      s2_word_q[p] <= s2_word_d[p];
    end
  end

endmodule

// File: tb/tb_xor_multiport_ram_pipelined.sv
// Bench: directed vector table on a 4-port instance, random LVT-style run on a 32-port instance.
module tb_xor_multiport_ram_pipelined;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Small instance: PORTS=4, WIDTH=8, DEPTH=16
  logic [3:0] addr_s [4];
  logic [3:0] en_s;
  logic [7:0] d_s [4];
  logic [7:0] q_s [4];

  // Large instance: PORTS=32, WIDTH=5, DEPTH=1024
  logic [9:0]  addr_b [32];
  logic [31:0] en_b;
  logic [4:0]  d_b [32];
  logic [4:0]  q_b [32];

  xor_multiport_ram_pipelined #(.WIDTH(8), .DEPTH(16), .PORTS(4)) dut_s (
    .clk(clk), .rst(rst), .addr(addr_s), .en(en_s), .d(d_s), .q(q_s)
  );

  xor_multiport_ram_pipelined #(.WIDTH(5), .DEPTH(1024), .PORTS(32)) dut_b (
    .clk(clk), .rst(rst), .addr(addr_b), .en(en_b), .d(d_b), .q(q_b)
  );

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0]      en;
    logic [3:0][3:0] addr;
    logic [3:0][7:0] d;
    logic [3:0]      chk;
    logic [3:0][7:0] exp;
  } vec_t;

  vec_t tbl [12];

  logic [4:0] gold  [1024];
  bit         known [1024];

  function automatic vec_t mkrow(input logic [3:0] en, input logic [15:0] a,
                                 input logic [31:0] dd, input logic [3:0] chk,
                                 input logic [31:0] e);
    vec_t r;
    r.en = en; r.addr = a; r.d = dd; r.chk = chk; r.exp = e;
    return r;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_small();
    en_s = '0;
    for (int p = 0; p < 4; p++) begin
      addr_s[p] = '0;
      d_s[p] = '0;
    end
  endtask

  task automatic check_small_zero(input string nm);
    for (int p = 0; p < 4; p++) check($sformatf("%s q%0d", nm, p), {24'b0, q_s[p]}, 32'h0);
  endtask

  task automatic small_write(input int p, input logic [3:0] a, input logic [7:0] v);
    idle_small();
    en_s[p] = 1'b1;
    addr_s[p] = a;
    d_s[p] = v;
  endtask

  task automatic small_read_check(input string nm, input int p, input logic [3:0] a,
                                  input logic [7:0] v);
    idle_small();
    addr_s[p] = a;
    tick();
    check(nm, {24'b0, q_s[p]}, {24'b0, v});
  endtask

  // Write in flight for `stages` edges, then reset; the old word must survive.
  task automatic midwrite_reset(input int stages, input logic [7:0] v);
    small_write(0, 4'd9, v);
    tick();
    idle_small();
    if (stages > 1) tick();
    rst = 1'b1;
    #1;
    check_small_zero($sformatf("midrst%0d async", stages));
    tick();
    tick();
    rst = 1'b0;
    small_read_check($sformatf("midrst%0d retain", stages), 1, 4'd9, 8'h77);
  endtask

  initial begin
    tbl[0]  = mkrow(4'b0001, 16'h0003, 32'h0000005A, 4'b0000, 32'h0);
    tbl[1]  = mkrow(4'b0000, 16'h0300, 32'h0,        4'b0100, 32'h005A0000);
    tbl[2]  = mkrow(4'b1111, 16'h3210, 32'h44332211, 4'b0000, 32'h0);
    tbl[3]  = mkrow(4'b0000, 16'h0321, 32'h0,        4'b1111, 32'h11443322);
    tbl[4]  = mkrow(4'b0001, 16'h0005, 32'h0000000F, 4'b0000, 32'h0);
    tbl[5]  = mkrow(4'b0010, 16'h5050, 32'h0000F000, 4'b1000, 32'h0F000000);
    tbl[6]  = mkrow(4'b0000, 16'h0005, 32'h0,        4'b0001, 32'h000000F0);
    tbl[7]  = mkrow(4'b0001, 16'h0007, 32'h000000AA, 4'b0000, 32'h0);
    tbl[8]  = mkrow(4'b0100, 16'h0770, 32'h00BB0000, 4'b0010, 32'h0000AA00);
    tbl[9]  = mkrow(4'b0000, 16'h0070, 32'h0,        4'b0010, 32'h0000BB00);
    tbl[10] = mkrow(4'b0000, 16'h7777, 32'h0,        4'b1111, 32'hBBBBBBBB);
    tbl[11] = mkrow(4'b0000, 16'h3210, 32'h0,        4'b1111, 32'h44332211);

    idle_small();
    en_b = '0;
    for (int p = 0; p < 32; p++) begin
      addr_b[p] = '0;
      d_b[p] = '0;
    end
    for (int a = 0; a < 1024; a++) begin
      gold[a] = '0;
      known[a] = 1'b0;
    end

    rst = 1'b1;
    tick();
    check_small_zero("rst1");
    tick();
    check_small_zero("rst2");
    for (int p = 0; p < 32; p++) check($sformatf("rst big q%0d", p), {27'b0, q_b[p]}, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      en_s = tbl[i].en;
      for (int p = 0; p < 4; p++) begin
        addr_s[p] = tbl[i].addr[p];
        d_s[p] = tbl[i].d[p];
      end
      tick();
      for (int p = 0; p < 4; p++) begin
        if (tbl[i].chk[p]) begin
          check($sformatf("vec%0d q%0d", i, p), {24'b0, q_s[p]}, {24'b0, tbl[i].exp[p]});
        end
      end
    end

    small_write(0, 4'd9, 8'h77);
    tick();
    small_read_check("pre midrst", 1, 4'd9, 8'h77);
    midwrite_reset(1, 8'h99);
    midwrite_reset(2, 8'hC3);
    idle_small();

    // Random LVT run: distinct addresses per cycle, small address window to force hazards.
    for (int cyc = 0; cyc < 1500; cyc++) begin
      logic [63:0] used;
      logic [4:0]  exp_q [32];
      bit          exp_k [32];
      used = '0;
      for (int p = 0; p < 32; p++) begin
        int a;
        a = $urandom_range(0, 63);
        addr_b[p] = a[9:0];
        en_b[p] = ($urandom_range(0, 1) == 1) && !used[a];
        if (en_b[p]) used[a] = 1'b1;
        d_b[p] = en_b[p] ? p[4:0] : 5'($urandom);
        exp_q[p] = gold[a];
        exp_k[p] = known[a];
      end
      tick();
      for (int p = 0; p < 32; p++) begin
        if (exp_k[p]) check($sformatf("lvt c%0d p%0d", cyc, p), {27'b0, q_b[p]}, {27'b0, exp_q[p]});
      end
      for (int p = 0; p < 32; p++) begin
        if (en_b[p]) begin
          gold[addr_b[p]] = p[4:0];
          known[addr_b[p]] = 1'b1;
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
